// File: rtl/data_mem_port.sv
// data_mem_port: byte/half/word load-store responder over a word-wide handshaked memory; sub-word stores are read-modify-write.
// Latency 3 cycles (load, word store), 4 (sub-word store), 2 (error), +1 per ack wait cycle; stall_out holds the PC, no timeout on mem_ack_in.
module data_mem_port #(
  parameter int ADDR_W = 10
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              re_in,
  input  logic              we_in,
  input  logic [1:0]        size_in,
  input  logic              signed_in,
  input  logic [31:0]       addr_in,
  input  logic [31:0]       wdata_in,
  output logic [31:0]       rdata_out,
  output logic              stall_out,
  output logic              done_out,
  output logic              err_out,
  output logic              mem_req_out,
  output logic              mem_we_out,
  output logic [ADDR_W-1:0] mem_addr_out,
  output logic [31:0]       mem_wdata_out,
  input  logic [31:0]       mem_rdata_in,
  input  logic              mem_ack_in
);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_BAD  = 2'b11;

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  typedef struct packed {
    logic              is_store;
    logic              is_signed;
    logic [1:0]        size;
    logic [1:0]        lane;
    logic [ADDR_W-1:0] waddr;
    logic [31:0]       wdata;
  } req_t;

  state_t      state;
  state_t      state_nxt;
  req_t        req_d;
  req_t        req_q;
  logic        req_vld;
  logic        req_err;
  logic        err_q;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;
  logic [31:0] merged;

  assign req_vld = re_in | we_in;

  always_comb begin
    req_d.is_store  = we_in;
    req_d.is_signed = signed_in;
    req_d.size      = size_in;
    req_d.lane      = addr_in[1:0];
    req_d.waddr     = addr_in[ADDR_W+1:2];
    req_d.wdata     = wdata_in;
  end

  always_comb begin
    req_err = 1'b0;
    case (size_in)
      SZ_HALF: req_err = addr_in[0];
      SZ_WORD: req_err = |addr_in[1:0];
      SZ_BAD:  req_err = 1'b1;
      default: req_err = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req_vld) begin
          if (req_err) begin
            state_nxt = RESP;
          end else if (we_in && (size_in == SZ_WORD)) begin
            state_nxt = WR;
          end else begin
            state_nxt = RD;
          end
        end
      end
      RD: begin
        if (mem_ack_in) begin
          state_nxt = req_q.is_store ? WR : RESP;
        end
      end
      WR: begin
        if (mem_ack_in) begin
          state_nxt = RESP;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state; only the IDLE stall looks at the request inputs
  always_comb begin
    stall_out   = 1'b0;
    done_out    = 1'b0;
    err_out     = 1'b0;
    mem_req_out = 1'b0;
    mem_we_out  = 1'b0;
    case (state)
      IDLE: stall_out = req_vld;
      RD: begin
        stall_out   = 1'b1;
        mem_req_out = 1'b1;
      end
      WR: begin
        stall_out   = 1'b1;
        mem_req_out = 1'b1;
        mem_we_out  = 1'b1;
      end
      RESP: begin
        done_out = 1'b1;
        err_out  = err_q;
      end
      default: stall_out = 1'b0;
    endcase
  end

  always_comb begin
    ld_byte = mem_rdata_in[7:0];
    case (req_q.lane)
      2'd1:    ld_byte = mem_rdata_in[15:8];
      2'd2:    ld_byte = mem_rdata_in[23:16];
      2'd3:    ld_byte = mem_rdata_in[31:24];
      default: ld_byte = mem_rdata_in[7:0];
    endcase
    ld_half = req_q.lane[1] ? mem_rdata_in[31:16] : mem_rdata_in[15:0];
    case (req_q.size)
      SZ_BYTE: ld_ext = {{24{req_q.is_signed & ld_byte[7]}}, ld_byte};
      SZ_HALF: ld_ext = {{16{req_q.is_signed & ld_half[15]}}, ld_half};
      default: ld_ext = mem_rdata_in;
    endcase
  end

  // Drop the latched byte/half into its lane of the word just read
  always_comb begin
    merged = mem_rdata_in;
    if (req_q.size == SZ_BYTE) begin
      case (req_q.lane)
        2'd0:    merged[7:0]   = req_q.wdata[7:0];
        2'd1:    merged[15:8]  = req_q.wdata[7:0];
        2'd2:    merged[23:16] = req_q.wdata[7:0];
        default: merged[31:24] = req_q.wdata[7:0];
      endcase
    end else if (req_q.size == SZ_HALF) begin
      if (req_q.lane[1]) begin
        merged[31:16] = req_q.wdata[15:0];
      end else begin
        merged[15:0] = req_q.wdata[15:0];
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      req_q         <= '0;
      err_q         <= 1'b0;
      rdata_out     <= '0;
      mem_wdata_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_vld) begin
            req_q <= req_d;
            err_q <= req_err;
            if (we_in && (size_in == SZ_WORD) && !req_err) begin
              mem_wdata_out <= wdata_in;
            end
          end
        end
        RD: begin
          if (mem_ack_in) begin
            if (req_q.is_store) begin
              mem_wdata_out <= merged;
            end else begin
              rdata_out <= ld_ext;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign mem_addr_out = req_q.waddr;

endmodule

// File: tb/tb_data_mem_port.sv
// Directed bench for data_mem_port: behavioural word memory with programmable ack delay,
// one task per scenario, hand-computed expectations.
module tb_data_mem_port;

  logic        clk = 1'b0;
  logic        rst_in = 1'b1;
  logic        re_in = 1'b0;
  logic        we_in = 1'b0;
  logic [1:0]  size_in = 2'b00;
  logic        signed_in = 1'b0;
  logic [31:0] addr_in = '0;
  logic [31:0] wdata_in = '0;
  logic [31:0] rdata_out;
  logic        stall_out;
  logic        done_out;
  logic        err_out;
  logic        mem_req_out;
  logic        mem_we_out;
  logic [9:0]  mem_addr_out;
  logic [31:0] mem_wdata_out;
  logic [31:0] mem_rdata_in = '0;
  logic        mem_ack_in = 1'b0;

  logic [31:0] mem [0:1023];
  int          ack_delay = 0;
  int          ack_cnt = 0;
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  int          req_cycles = 0;

  int          vectors = 0;
  int          miscompares = 0;

  int          cyc;
  int          stl;
  logic        dn;
  logic        er;
  logic [31:0] rd;
  logic [31:0] ws;
  logic [9:0]  as;

  data_mem_port #(.ADDR_W(10)) dut (
    .clk_in(clk), .rst_in(rst_in), .re_in(re_in), .we_in(we_in),
    .size_in(size_in), .signed_in(signed_in), .addr_in(addr_in), .wdata_in(wdata_in),
    .rdata_out(rdata_out), .stall_out(stall_out), .done_out(done_out), .err_out(err_out),
    .mem_req_out(mem_req_out), .mem_we_out(mem_we_out), .mem_addr_out(mem_addr_out),
    .mem_wdata_out(mem_wdata_out), .mem_rdata_in(mem_rdata_in), .mem_ack_in(mem_ack_in)
  );

  always #5 clk = ~clk;

  // Memory model: acks after ack_delay waiting cycles, garbage on rdata when not acking
  always @(negedge clk) begin
    if (mem_ack_in) ack_cnt = 0;
    if (mem_req_out) begin
      req_cycles++;
      if (ack_cnt >= ack_delay) begin
        mem_ack_in = 1'b1;
        if (mem_we_out) begin
          mem[mem_addr_out] = mem_wdata_out;
          wr_cnt++;
        end else begin
          mem_rdata_in = mem[mem_addr_out];
          rd_cnt++;
        end
      end else begin
        mem_ack_in = 1'b0;
        mem_rdata_in = 32'h5A5A5A5A;
        ack_cnt++;
      end
    end else begin
      mem_ack_in = 1'b0;
      mem_rdata_in = 32'h5A5A5A5A;
      ack_cnt = 0;
    end
  end

  task automatic run_access(input logic r, input logic w, input logic [1:0] sz, input logic sg,
                            input logic [31:0] a, input logic [31:0] wd, input int dly);
    logic fin;
    logic as_vld;
    ack_delay = dly;
    @(negedge clk);
    re_in = r; we_in = w; size_in = sz; signed_in = sg; addr_in = a; wdata_in = wd;
    cyc = 0; stl = 0; dn = 1'b0; er = 1'b0; rd = '0; ws = '0; as = '0;
    fin = 1'b0; as_vld = 1'b0;
    while (!fin) begin
      #1;
      cyc++;
      if (stall_out) stl++;
      if (mem_req_out && !as_vld) begin as = mem_addr_out; as_vld = 1'b1; end
      if (mem_req_out && mem_we_out) ws = mem_wdata_out;
      if (done_out) begin
        dn = 1'b1; er = err_out; rd = rdata_out; fin = 1'b1;
      end else if (cyc >= 60) begin
        fin = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    re_in = 1'b0; we_in = 1'b0;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    vectors++; if (rdata_out !== 32'h0) begin miscompares++; $display("FAIL rst_rdata got %h want 0", rdata_out); end
    vectors++; if ({done_out, err_out, mem_req_out, mem_we_out, stall_out} !== 5'b0) begin miscompares++; $display("FAIL rst_ctrl got %b want 00000", {done_out, err_out, mem_req_out, mem_we_out, stall_out}); end
    vectors++; if (mem_addr_out !== 10'h0 || mem_wdata_out !== 32'h0) begin miscompares++; $display("FAIL rst_mem_bus got addr %h wdata %h want 0 0", mem_addr_out, mem_wdata_out); end
    rst_in = 1'b0;
  endtask

  task automatic test_word_load;
    run_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000000C, 32'h0, 2);
    vectors++; if (dn !== 1'b1 || er !== 1'b0) begin miscompares++; $display("FAIL wload_done got dn %b err %b want 1 0", dn, er); end
    vectors++; if (as !== 10'd3) begin miscompares++; $display("FAIL wload_addr got %0d want 3", as); end
    vectors++; if (rd !== 32'h8899AABB) begin miscompares++; $display("FAIL wload_rdata got %h want 8899aabb", rd); end
    // IDLE + three RD cycles stalled, then the unstalled RESP cycle
    vectors++; if (cyc !== 5 || stl !== 4) begin miscompares++; $display("FAIL wload_timing got cyc %0d stall %0d want 5 4", cyc, stl); end
  endtask

  task automatic test_subword_load;
    run_access(1'b1, 1'b0, 2'b00, 1'b1, 32'h0000000D, 32'h0, 0);
    vectors++; if (rd !== 32'hFFFFFFAA || cyc !== 3) begin miscompares++; $display("FAIL lb_signed got %h cyc %0d want ffffffaa 3", rd, cyc); end
    run_access(1'b1, 1'b0, 2'b00, 1'b0, 32'h0000000D, 32'h0, 0);
    vectors++; if (rd !== 32'h000000AA) begin miscompares++; $display("FAIL lbu got %h want 000000aa", rd); end
    run_access(1'b1, 1'b0, 2'b00, 1'b0, 32'h0000000F, 32'h0, 1);
    vectors++; if (rd !== 32'h00000088 || cyc !== 4) begin miscompares++; $display("FAIL lbu_top got %h cyc %0d want 00000088 4", rd, cyc); end
    run_access(1'b1, 1'b0, 2'b01, 1'b1, 32'h0000000E, 32'h0, 0);
    vectors++; if (rd !== 32'hFFFF8899) begin miscompares++; $display("FAIL lh_signed got %h want ffff8899", rd); end
    run_access(1'b1, 1'b0, 2'b01, 1'b0, 32'h0000000C, 32'h0, 0);
    vectors++; if (rd !== 32'h0000AABB) begin miscompares++; $display("FAIL lhu_low got %h want 0000aabb", rd); end
  endtask

  task automatic test_subword_store;
    int r0, w0;
    r0 = rd_cnt; w0 = wr_cnt;
    run_access(1'b0, 1'b1, 2'b00, 1'b0, 32'h0000000E, 32'h00000055, 0);
    vectors++; if (dn !== 1'b1 || cyc !== 4 || er !== 1'b0) begin miscompares++; $display("FAIL sb_timing got dn %b cyc %0d err %b want 1 4 0", dn, cyc, er); end
    vectors++; if (rd_cnt - r0 !== 1 || wr_cnt - w0 !== 1) begin miscompares++; $display("FAIL sb_txns got rd %0d wr %0d want 1 1", rd_cnt - r0, wr_cnt - w0); end
    vectors++; if (ws !== 32'h8855AABB || mem[3] !== 32'h8855AABB) begin miscompares++; $display("FAIL sb_merge got bus %h mem %h want 8855aabb", ws, mem[3]); end
    vectors++; if (rd !== 32'h0000AABB) begin miscompares++; $display("FAIL sb_rdata_hold got %h want 0000aabb", rd); end
    run_access(1'b0, 1'b1, 2'b01, 1'b0, 32'h0000000C, 32'hFFFF1234, 1);
    vectors++; if (mem[3] !== 32'h88551234 || cyc !== 6) begin miscompares++; $display("FAIL sh_merge got mem %h cyc %0d want 88551234 6", mem[3], cyc); end
    run_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000000C, 32'h0, 0);
    vectors++; if (rd !== 32'h88551234) begin miscompares++; $display("FAIL sh_readback got %h want 88551234", rd); end
  endtask

  task automatic test_misaligned;
    int q0;
    q0 = req_cycles;
    run_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000000D, 32'h0, 0);
    vectors++; if (dn !== 1'b1 || er !== 1'b1 || cyc !== 2) begin miscompares++; $display("FAIL mis_lw got dn %b err %b cyc %0d want 1 1 2", dn, er, cyc); end
    vectors++; if (rd !== 32'h88551234) begin miscompares++; $display("FAIL mis_lw_rdata got %h want 88551234", rd); end
    run_access(1'b0, 1'b1, 2'b01, 1'b0, 32'h0000000F, 32'h0000BEEF, 0);
    vectors++; if (dn !== 1'b1 || er !== 1'b1 || cyc !== 2) begin miscompares++; $display("FAIL mis_sh got dn %b err %b cyc %0d want 1 1 2", dn, er, cyc); end
    run_access(1'b1, 1'b0, 2'b11, 1'b0, 32'h0000000C, 32'h0, 0);
    vectors++; if (er !== 1'b1 || cyc !== 2) begin miscompares++; $display("FAIL bad_size got err %b cyc %0d want 1 2", er, cyc); end
    vectors++; if (req_cycles !== q0 || mem[3] !== 32'h88551234) begin miscompares++; $display("FAIL mis_no_txn got req %0d mem %h want 0 88551234", req_cycles - q0, mem[3]); end
  endtask

  task automatic test_back_to_back;
    int n;
    logic fin;
    ack_delay = 0;
    @(negedge clk);
    we_in = 1'b1; size_in = 2'b10; addr_in = 32'h00000020; wdata_in = 32'hDEADBEEF;
    n = 0; fin = 1'b0;
    while (!fin) begin
      #1; n++;
      if (done_out || n >= 40) fin = 1'b1; else @(negedge clk);
    end
    vectors++; if (done_out !== 1'b1 || err_out !== 1'b0 || n !== 3) begin miscompares++; $display("FAIL b2b_store got done %b err %b cyc %0d want 1 0 3", done_out, err_out, n); end
    // next request presented during RESP, must be taken in the following IDLE
    we_in = 1'b0; re_in = 1'b1;
    @(negedge clk); #1;
    vectors++; if (done_out !== 1'b0 || stall_out !== 1'b1 || mem_req_out !== 1'b0) begin miscompares++; $display("FAIL b2b_idle got done %b stall %b req %b want 0 1 0", done_out, stall_out, mem_req_out); end
    @(negedge clk); #1;
    vectors++; if (mem_req_out !== 1'b1 || mem_we_out !== 1'b0 || mem_addr_out !== 10'd8) begin miscompares++; $display("FAIL b2b_accept got req %b we %b addr %0d want 1 0 8", mem_req_out, mem_we_out, mem_addr_out); end
    n = 0; fin = 1'b0;
    while (!fin) begin
      if (done_out || n >= 40) fin = 1'b1; else begin @(negedge clk); #1; n++; end
    end
    re_in = 1'b0;
    vectors++; if (done_out !== 1'b1 || rdata_out !== 32'hDEADBEEF || mem[8] !== 32'hDEADBEEF) begin miscompares++; $display("FAIL b2b_load got done %b rdata %h mem %h want 1 deadbeef", done_out, rdata_out, mem[8]); end
  endtask

  task automatic test_reset_mid_access;
    int n;
    int w0;
    logic seen;
    ack_delay = 1000;
    w0 = wr_cnt;
    @(negedge clk);
    we_in = 1'b1; size_in = 2'b10; addr_in = 32'h00000010; wdata_in = 32'hCAFEF00D;
    seen = 1'b0; n = 0;
    while (!seen && n < 10) begin
      #1;
      if (mem_req_out && mem_we_out) seen = 1'b1; else begin n++; @(negedge clk); end
    end
    vectors++; if (seen !== 1'b1) begin miscompares++; $display("FAIL rstwr_enter got %b want 1", seen); end
    @(negedge clk);
    rst_in = 1'b1; we_in = 1'b0;
    @(negedge clk); #1;
    vectors++; if (mem_req_out !== 1'b0 || done_out !== 1'b0 || mem_we_out !== 1'b0 || stall_out !== 1'b0) begin miscompares++; $display("FAIL rstwr_ctrl got req %b done %b we %b stall %b want 0 0 0 0", mem_req_out, done_out, mem_we_out, stall_out); end
    vectors++; if (rdata_out !== 32'h0 || mem_wdata_out !== 32'h0) begin miscompares++; $display("FAIL rstwr_data got rdata %h wdata %h want 0 0", rdata_out, mem_wdata_out); end
    vectors++; if (wr_cnt !== w0 || mem[4] !== 32'h0) begin miscompares++; $display("FAIL rstwr_mem got writes %0d mem %h want 0 0", wr_cnt - w0, mem[4]); end
    re_in = 1'b1; #1;
    vectors++; if (stall_out !== 1'b1) begin miscompares++; $display("FAIL rstwr_idle_stall got %b want 1", stall_out); end
    re_in = 1'b0; rst_in = 1'b0; ack_delay = 0;
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[3] = 32'h8899AABB;
    test_reset();
    test_word_load();
    test_subword_load();
    test_subword_store();
    test_misaligned();
    test_back_to_back();
    test_reset_mid_access();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
